// File: rtl/ibus_dbus_arbiter.sv
// 2-to-1 Avalon-MM arbiter (m0 = ibus, m1 = dbus) sharing one pipelined slave port, with
// an in-order read-id FIFO for response routing. Define ARB_ROUND_ROBIN_EN for alternating priority.
module ibus_dbus_arbiter #(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               m0_read,
  input  logic                               m0_write,
  input  logic [AW-1:0]                      m0_address,
  input  logic [DW-1:0]                      m0_writedata,
  input  logic [DW/8-1:0]                    m0_byteenable,
  output logic                               m0_waitrequest,
  output logic                               m0_readdatavalid,
  output logic [DW-1:0]                      m0_readdata,
  input  logic                               m1_read,
  input  logic                               m1_write,
  input  logic [AW-1:0]                      m1_address,
  input  logic [DW-1:0]                      m1_writedata,
  input  logic [DW/8-1:0]                    m1_byteenable,
  output logic                               m1_waitrequest,
  output logic                               m1_readdatavalid,
  output logic [DW-1:0]                      m1_readdata,
  output logic                               s_read,
  output logic                               s_write,
  output logic [AW-1:0]                      s_address,
  output logic [DW-1:0]                      s_writedata,
  output logic [DW/8-1:0]                    s_byteenable,
  input  logic                               s_waitrequest,
  input  logic                               s_readdatavalid,
  input  logic [DW-1:0]                      s_readdata,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err_unexpected_rsp
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  logic                       lock_q, lock_d;
  logic                       gnt_id_q;
  logic [MAX_OUTSTANDING-1:0] fifo_q;
  logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]              count_q;
  logic                       err_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic                       last_grant_q;
`endif

  logic req0_s, req1_s, gnt_valid_s, gnt_id_s;
  logic gnt_read_s, gnt_write_s, gnt_req_s, read_block_s;
  logic accept_s, push_s, pop_s, head_s;

  assign req0_s = m0_read | m0_write;
  assign req1_s = m1_read | m1_write;

  // While locked the registered grant is replayed; otherwise arbitrate this cycle's requests.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_id_s    = 1'b0;
    if (lock_q) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = gnt_id_q;
    end else if (req0_s && req1_s) begin
      gnt_valid_s = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      gnt_id_s    = ~last_grant_q;
`else
      gnt_id_s    = 1'b1;
`endif
    end else if (req1_s) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = 1'b1;
    end else if (req0_s) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = 1'b0;
    end else begin
      gnt_valid_s = 1'b0;
      gnt_id_s    = 1'b0;
    end
  end

  assign gnt_read_s   = gnt_valid_s & (gnt_id_s ? m1_read  : m0_read);
  assign gnt_write_s  = gnt_valid_s & (gnt_id_s ? m1_write : m0_write);
  assign gnt_req_s    = gnt_read_s | gnt_write_s;
  // A pop in the same cycle does not free a slot for the blocked read.
  assign read_block_s = gnt_read_s & (count_q == CNT_MAX);

  assign s_read       = gnt_read_s & ~read_block_s;
  assign s_write      = gnt_write_s;
  assign s_address    = gnt_id_s ? m1_address    : m0_address;
  assign s_writedata  = gnt_id_s ? m1_writedata  : m0_writedata;
  assign s_byteenable = gnt_id_s ? m1_byteenable : m0_byteenable;

  assign m0_waitrequest = ~(gnt_valid_s & ~gnt_id_s) | s_waitrequest | read_block_s;
  assign m1_waitrequest = ~(gnt_valid_s &  gnt_id_s) | s_waitrequest | read_block_s;

  assign accept_s = (s_read | s_write) & ~s_waitrequest;
  assign push_s   = accept_s & s_read;
  assign pop_s    = s_readdatavalid & (count_q != {CW{1'b0}});
  assign head_s   = fifo_q[rd_ptr_q];
  assign lock_d   = gnt_req_s & (s_waitrequest | read_block_s);

  assign m0_readdatavalid   = pop_s & ~head_s;
  assign m1_readdatavalid   = pop_s &  head_s;
  assign m0_readdata        = s_readdata;
  assign m1_readdata        = s_readdata;
  assign outstanding        = count_q;
  assign err_unexpected_rsp = err_q;

  // Lock/grant, read-id FIFO, occupancy and sticky error state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q   <= 1'b0;
      gnt_id_q <= 1'b0;
      fifo_q   <= {MAX_OUTSTANDING{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      err_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      lock_q   <= lock_d;
      gnt_id_q <= gnt_id_s;
      if (push_s) begin
        fifo_q[wr_ptr_q] <= gnt_id_s;
        wr_ptr_q         <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      if (s_readdatavalid && (count_q == {CW{1'b0}})) begin
        err_q <= 1'b1;
      end
`ifdef ARB_ROUND_ROBIN_EN
      if (accept_s) begin
        last_grant_q <= gnt_id_s;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ibus_dbus_arbiter.sv
// Self-checking bench for ibus_dbus_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_ibus_dbus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic m0_read, m0_write, m1_read, m1_write;
  logic [AW-1:0] m0_address, m1_address, s_address;
  logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
  logic [BW-1:0] m0_byteenable, m1_byteenable, s_byteenable;
  logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata, s_readdata;
  logic s_read, s_write, s_waitrequest, s_readdatavalid;
  logic [$clog2(MAXO):0] outstanding;
  logic err_unexpected_rsp;

  int checks = 0;
  int errors = 0;

  ibus_dbus_arbiter #(.AW(AW), .DW(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdatavalid(m0_readdatavalid), .m0_readdata(m0_readdata),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdatavalid(m1_readdatavalid), .m1_readdata(m1_readdata),
    .s_read(s_read), .s_write(s_write), .s_address(s_address),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdatavalid(s_readdatavalid), .s_readdata(s_readdata),
    .outstanding(outstanding), .err_unexpected_rsp(err_unexpected_rsp)
  );

  // Reference model state: queue of issuing-master ids for accepted reads.
  bit q[$];
  bit m_lock, m_lock_id, m_err;
`ifdef ARB_ROUND_ROBIN_EN
  bit m_last;
`endif
  bit e_gv, e_gid, e_sr, e_sw, e_w0, e_w1, e_v0, e_v1, e_acc, e_req, e_blk;

  task automatic model_eval();
    bit r0, r1, grd, gwr;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    e_gv = m_lock | r0 | r1;
    if (m_lock) e_gid = m_lock_id;
    else if (r0 && r1) begin
`ifdef ARB_ROUND_ROBIN_EN
      e_gid = !m_last;
`else
      e_gid = 1'b1;
`endif
    end else e_gid = r1;
    grd = e_gv && (e_gid ? m1_read : m0_read);
    gwr = e_gv && (e_gid ? m1_write : m0_write);
    e_blk = grd && (q.size() == MAXO);
    e_sr = grd && !e_blk;
    e_sw = gwr;
    e_req = grd || gwr;
    if (e_gv && e_gid == 1'b0) e_w0 = s_waitrequest || e_blk; else e_w0 = 1'b1;
    if (e_gv && e_gid == 1'b1) e_w1 = s_waitrequest || e_blk; else e_w1 = 1'b1;
    e_acc = (e_sr || e_sw) && !s_waitrequest;
    e_v0 = s_readdatavalid && (q.size() > 0) && (q[0] == 1'b0);
    e_v1 = s_readdatavalid && (q.size() > 0) && (q[0] == 1'b1);
  endtask

  task automatic model_commit();
    if (s_readdatavalid) begin
      if (q.size() > 0) void'(q.pop_front());
      else m_err = 1'b1;
    end
    if (e_acc && e_sr) q.push_back(e_gid);
    m_lock = e_req && (s_waitrequest || e_blk);
    m_lock_id = e_gid;
`ifdef ARB_ROUND_ROBIN_EN
    if (e_acc) m_last = e_gid;
`endif
  endtask

  task automatic set_idle();
    m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_writedata = '0; m0_byteenable = '0;
    m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_writedata = '0; m1_byteenable = '0;
    s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    q.delete();
    m_lock = 1'b0; m_lock_id = 1'b0; m_err = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    m_last = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    @(negedge clk); #1;
    checks++;
    if (outstanding !== 3'd0 || err_unexpected_rsp !== 1'b0 || s_read !== 1'b0 || s_write !== 1'b0 ||
        m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: outst=%0d err=%b s_rd=%b s_wr=%b rdv0=%b rdv1=%b, required all 0",
               outstanding, err_unexpected_rsp, s_read, s_write, m0_readdatavalid, m1_readdatavalid);
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 || s_read !== 1'b0 || s_write !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: w0=%b w1=%b s_rd=%b s_wr=%b, required 1 1 0 0",
               m0_waitrequest, m1_waitrequest, s_read, s_write);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    @(negedge clk); m0_read = 1'b1; m0_address = 32'h100; #1;
    checks++;
    if (s_read !== 1'b1 || s_address !== 32'h100 || m0_waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL single_issue: s_read=%b addr=%h w0=%b, required 1 00000100 0", s_read, s_address, m0_waitrequest);
    end
    @(negedge clk); m0_read = 1'b0; #1;
    checks++;
    if (outstanding !== 3'd1) begin
      errors++; $display("FAIL single_outst1: got %0d, required 1", outstanding);
    end
    @(negedge clk); s_readdatavalid = 1'b1; s_readdata = 32'hDEADBEEF; #1;
    checks++;
    if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0 || m0_readdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_rsp: rdv0=%b rdv1=%b data=%h, required 1 0 deadbeef",
               m0_readdatavalid, m1_readdatavalid, m0_readdata);
    end
    @(negedge clk); s_readdatavalid = 1'b0; #1;
    checks++;
    if (outstanding !== 3'd0) begin
      errors++; $display("FAIL single_outst0: got %0d, required 0", outstanding);
    end
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m0_read = 1'b1; m0_address = 32'h100;
      m1_write = 1'b1; m1_address = 32'h200; m1_writedata = 32'h1234;
      s_waitrequest = (i < 3); #1;
      checks++;
      if (s_address !== 32'h200 || s_write !== 1'b1 || s_read !== 1'b0 || m0_waitrequest !== 1'b1 ||
          m1_waitrequest !== logic'(i < 3)) begin
        errors++;
        $display("FAIL contention_c%0d: addr=%h s_wr=%b s_rd=%b w0=%b w1=%b, required 00000200 1 0 1 %0d",
                 i, s_address, s_write, s_read, m0_waitrequest, m1_waitrequest, (i < 3));
      end
    end
    @(negedge clk); m1_write = 1'b0; s_waitrequest = 1'b0; #1;
    checks++;
    if (s_read !== 1'b1 || s_address !== 32'h100 || m0_waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL contention_m0_next: s_rd=%b addr=%h w0=%b, required 1 00000100 0", s_read, s_address, m0_waitrequest);
    end
    @(negedge clk); m0_read = 1'b0; s_readdatavalid = 1'b1; s_readdata = 32'h55; #1;
    checks++;
    if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL contention_rsp: rdv0=%b rdv1=%b, required 1 0", m0_readdatavalid, m1_readdatavalid);
    end
    // m0 stalls first; a later m1 request must not steal the locked grant.
    @(negedge clk); s_readdatavalid = 1'b0; m0_read = 1'b1; m0_address = 32'h140; s_waitrequest = 1'b1;
    @(negedge clk); m1_read = 1'b1; m1_address = 32'h240; #1;
    checks++;
    if (s_address !== 32'h140 || m1_waitrequest !== 1'b1) begin
      errors++; $display("FAIL lock_hold: addr=%h w1=%b, required 00000140 1", s_address, m1_waitrequest);
    end
    @(negedge clk); s_waitrequest = 1'b0; #1;
    checks++;
    if (s_address !== 32'h140 || m0_waitrequest !== 1'b0 || s_read !== 1'b1) begin
      errors++; $display("FAIL lock_accept: addr=%h w0=%b s_rd=%b, required 00000140 0 1", s_address, m0_waitrequest, s_read);
    end
    @(negedge clk); m0_read = 1'b0; #1;
    checks++;
    if (s_address !== 32'h240 || m1_waitrequest !== 1'b0 || s_read !== 1'b1) begin
      errors++; $display("FAIL lock_release: addr=%h w1=%b s_rd=%b, required 00000240 0 1", s_address, m1_waitrequest, s_read);
    end
    @(negedge clk); m1_read = 1'b0; s_readdatavalid = 1'b1; #1;
    checks++;
    if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL lock_rsp0: rdv0=%b rdv1=%b, required 1 0", m0_readdatavalid, m1_readdatavalid);
    end
    @(negedge clk); #1;
    checks++;
    if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b1) begin
      errors++; $display("FAIL lock_rsp1: rdv0=%b rdv1=%b, required 0 1", m0_readdatavalid, m1_readdatavalid);
    end
    @(negedge clk); s_readdatavalid = 1'b0;
  endtask

  task automatic test_interleaved();
    bit exp_id[3];
    exp_id = '{1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      m0_read = !exp_id[i]; m0_address = 32'h10 + 32'(i);
      m1_read = exp_id[i];  m1_address = 32'h20 + 32'(i); #1;
      checks++;
      if (s_read !== 1'b1 || (exp_id[i] ? m1_waitrequest : m0_waitrequest) !== 1'b0) begin
        errors++; $display("FAIL interleave_issue%0d: s_rd=%b w0=%b w1=%b", i, s_read, m0_waitrequest, m1_waitrequest);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); m0_read = 1'b0; m1_read = 1'b0;
      s_readdatavalid = 1'b1; s_readdata = 32'(i + 1); #1;
      checks++;
      if (m0_readdatavalid !== !exp_id[i] || m1_readdatavalid !== exp_id[i] ||
          m0_readdata !== 32'(i + 1) || m1_readdata !== 32'(i + 1) || outstanding !== 3'(3 - i)) begin
        errors++;
        $display("FAIL interleave_rsp%0d: rdv0=%b rdv1=%b data=%h outst=%0d, required %b %b %0d %0d",
                 i, m0_readdatavalid, m1_readdatavalid, m0_readdata, outstanding, !exp_id[i], exp_id[i], i + 1, 3 - i);
      end
    end
    @(negedge clk); s_readdatavalid = 1'b0; #1;
    checks++;
    if (outstanding !== 3'd0) begin
      errors++; $display("FAIL interleave_drain: outst=%0d, required 0", outstanding);
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); m1_read = 1'b1; m1_address = 32'h300 + 32'(4 * i); #1;
      checks++;
      if (s_read !== 1'b1) begin
        errors++; $display("FAIL full_fill%0d: s_rd=%b, required 1", i, s_read);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); m1_address = 32'h400; s_readdatavalid = (i == 2); #1;
      checks++;
      if (s_read !== 1'b0 || m1_waitrequest !== 1'b1 || outstanding !== 3'd4 || m1_readdatavalid !== logic'(i == 2)) begin
        errors++;
        $display("FAIL full_block%0d: s_rd=%b w1=%b outst=%0d rdv1=%b, required 0 1 4 %0d",
                 i, s_read, m1_waitrequest, outstanding, m1_readdatavalid, (i == 2));
      end
    end
    @(negedge clk); s_readdatavalid = 1'b0; #1;
    checks++;
    if (s_read !== 1'b1 || m1_waitrequest !== 1'b0 || outstanding !== 3'd3) begin
      errors++; $display("FAIL full_unblock: s_rd=%b w1=%b outst=%0d, required 1 0 3", s_read, m1_waitrequest, outstanding);
    end
    @(negedge clk); m1_read = 1'b0; #1;
    checks++;
    if (outstanding !== 3'd4) begin
      errors++; $display("FAIL full_peak: outst=%0d, required 4", outstanding);
    end
    s_readdatavalid = 1'b1;
    repeat (4) @(negedge clk);
    s_readdatavalid = 1'b0; #1;
    checks++;
    if (outstanding !== 3'd0 || err_unexpected_rsp !== 1'b0) begin
      errors++; $display("FAIL full_drain: outst=%0d err=%b, required 0 0", outstanding, err_unexpected_rsp);
    end
  endtask

  task automatic test_error_reset();
    do_reset();
    @(negedge clk); s_readdatavalid = 1'b1; #1;
    checks++;
    if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0 || err_unexpected_rsp !== 1'b0) begin
      errors++; $display("FAIL err_drop: rdv0=%b rdv1=%b err=%b, required 0 0 0", m0_readdatavalid, m1_readdatavalid, err_unexpected_rsp);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); s_readdatavalid = 1'b0; #1;
      checks++;
      if (err_unexpected_rsp !== 1'b1) begin
        errors++; $display("FAIL err_sticky%0d: err=%b, required 1", i, err_unexpected_rsp);
      end
    end
    @(negedge clk); m0_read = 1'b1; m0_address = 32'h500;
    @(negedge clk); m0_address = 32'h504; s_waitrequest = 1'b1; #1;
    checks++;
    if (outstanding !== 3'd1 || m0_waitrequest !== 1'b1) begin
      errors++; $display("FAIL err_prestall: outst=%0d w0=%b, required 1 1", outstanding, m0_waitrequest);
    end
    @(negedge clk); m1_read = 1'b1; m1_address = 32'h600; s_readdatavalid = 1'b1;
    #2; rst = 1'b1; #1;
    checks++;
    if (err_unexpected_rsp !== 1'b0 || outstanding !== 3'd0 || m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL err_async_rst: err=%b outst=%0d rdv0=%b rdv1=%b, required 0 0 0 0",
               err_unexpected_rsp, outstanding, m0_readdatavalid, m1_readdatavalid);
    end
    @(negedge clk); #1;
    checks++;
    if (err_unexpected_rsp !== 1'b0) begin
      errors++; $display("FAIL err_in_rst: err=%b, required 0", err_unexpected_rsp);
    end
    @(negedge clk); rst = 1'b0; s_readdatavalid = 1'b0; s_waitrequest = 1'b0; #1;
    checks++;
    if (s_address !== 32'h600 || m1_waitrequest !== 1'b0 || err_unexpected_rsp !== 1'b0 || outstanding !== 3'd0) begin
      errors++;
      $display("FAIL err_post_rst: addr=%h w1=%b err=%b outst=%0d, required 00000600 0 0 0",
               s_address, m1_waitrequest, err_unexpected_rsp, outstanding);
    end
    @(negedge clk); set_idle();
  endtask

  task automatic test_priority();
    bit exp_id;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      m0_read = 1'b1; m0_address = 32'hA0;
      m1_read = 1'b1; m1_address = 32'hB0;
      s_readdatavalid = (i > 0); #1;
`ifdef ARB_ROUND_ROBIN_EN
      exp_id = (i % 2 == 0);
`else
      exp_id = 1'b1;
`endif
      checks++;
      if (s_read !== 1'b1 || s_address !== (exp_id ? 32'hB0 : 32'hA0)) begin
        errors++; $display("FAIL priority_c%0d: s_rd=%b addr=%h, required 1 %h", i, s_read, s_address, (exp_id ? 32'hB0 : 32'hA0));
      end
    end
    @(negedge clk); m0_read = 1'b0; m1_read = 1'b0; s_readdatavalid = 1'b1;
    @(negedge clk); s_readdatavalid = 1'b0; #1;
    checks++;
    if (outstanding !== 3'd0) begin
      errors++; $display("FAIL priority_drain: outst=%0d, required 0", outstanding);
    end
  endtask

  task automatic test_random();
    bit hold0, hold1;
    int op;
    do_reset();
    hold0 = 1'b0; hold1 = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (!hold0) begin
        op = $urandom_range(0, 3);
        m0_read = (op == 1 || op == 3); m0_write = (op == 2);
        m0_address = $urandom; m0_writedata = $urandom; m0_byteenable = BW'($urandom);
      end
      if (!hold1) begin
        op = $urandom_range(0, 3);
        m1_read = (op == 1 || op == 3); m1_write = (op == 2);
        m1_address = $urandom; m1_writedata = $urandom; m1_byteenable = BW'($urandom);
      end
      s_waitrequest = ($urandom_range(0, 3) == 0);
      s_readdatavalid = (q.size() != 0) && ($urandom_range(0, 4) < 2);
      s_readdata = $urandom;
      #1;
      model_eval();
      checks++;
      if (s_read !== e_sr || s_write !== e_sw) begin
        errors++; $display("FAIL rnd_strobe c%0d: s_rd=%b s_wr=%b, required %b %b", c, s_read, s_write, e_sr, e_sw);
      end
      checks++;
      if (m0_waitrequest !== e_w0 || m1_waitrequest !== e_w1) begin
        errors++; $display("FAIL rnd_wait c%0d: w0=%b w1=%b, required %b %b", c, m0_waitrequest, m1_waitrequest, e_w0, e_w1);
      end
      checks++;
      if (m0_readdatavalid !== e_v0 || m1_readdatavalid !== e_v1 || m0_readdata !== s_readdata || m1_readdata !== s_readdata) begin
        errors++; $display("FAIL rnd_rsp c%0d: rdv0=%b rdv1=%b, required %b %b", c, m0_readdatavalid, m1_readdatavalid, e_v0, e_v1);
      end
      if (e_gv) begin
        checks++;
        if (s_address !== (e_gid ? m1_address : m0_address) || s_writedata !== (e_gid ? m1_writedata : m0_writedata) ||
            s_byteenable !== (e_gid ? m1_byteenable : m0_byteenable)) begin
          errors++; $display("FAIL rnd_mux c%0d: addr=%h, required master %0d fields", c, s_address, e_gid);
        end
      end
      checks++;
      if (outstanding !== 3'(q.size()) || err_unexpected_rsp !== m_err) begin
        errors++; $display("FAIL rnd_state c%0d: outst=%0d err=%b, required %0d %b", c, outstanding, err_unexpected_rsp, q.size(), m_err);
      end
      hold0 = (m0_read | m0_write) & e_w0;
      hold1 = (m1_read | m1_write) & e_w1;
      model_commit();
    end
    @(negedge clk); set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_single_read();
    test_contention();
    test_interleaved();
    test_fifo_full();
    test_error_reset();
    test_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
